// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter that serialises NREQ simple request ports onto a single
// AXI-Lite master command port, with an alignment check and a completion timeout.
module axil_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 m_start,
    output logic                 m_we,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_wdata,
    input  logic                 m_done,
    input  logic                 m_error,
    input  logic [31:0]          m_rdata,
    output logic                 busy,
    output logic                 timeout_o
);
    localparam int              IW       = $clog2(NREQ);
    localparam logic [15:0]     TO_CNT   = 16'(TIMEOUT);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_last_grant;
    logic [IW-1:0]   r_grant;
    logic [15:0]     r_cnt;

    logic            w_found;
    logic [IW-1:0]   w_win;
    int              w_best;
    int              w_dist;
    logic            w_win_we;
    logic [31:0]     w_win_addr;
    logic [31:0]     w_win_wdata;

    // Winner is the valid requester at the smallest distance past the last grant
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last_grant;
        w_best  = NREQ;
        w_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i + NREQ - 1 - int'(r_last_grant)) % NREQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_win   = IW'(i);
                w_best  = w_dist;
            end else begin
                w_best  = w_best;
            end
        end
    end

    assign w_win_we    = req_we[w_win];
    assign w_win_addr  = req_addr[32*w_win +: 32];
    assign w_win_wdata = req_wdata[32*w_win +: 32];

    // Acceptance is offered only in IDLE and only to the current winner
    always_comb begin
        req_ready = '0;
        if ((r_state == ST_IDLE) && w_found) begin
            req_ready[w_win] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Transaction FSM; every output below is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= LAST_RST;
            r_grant      <= '0;
            r_cnt        <= 16'd0;
            rsp_valid    <= '0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            m_start      <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= 32'd0;
            m_wdata      <= 32'd0;
            busy         <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            m_start   <= 1'b0;
            rsp_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        m_we         <= w_win_we;
                        m_addr       <= w_win_addr;
                        m_wdata      <= w_win_wdata;
                        busy         <= 1'b1;
                        // Misaligned requests complete with an error without touching the bus
                        if (w_win_addr[1:0] != 2'b00) begin
                            r_state          <= ST_RESP;
                            rsp_valid[w_win] <= 1'b1;
                            rsp_err          <= 1'b1;
                            rsp_rdata        <= 32'd0;
                        end else begin
                            r_state <= ST_ISSUE;
                            m_start <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= 16'd1;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        r_state            <= ST_RESP;
                        rsp_valid[r_grant] <= 1'b1;
                        rsp_err            <= m_error;
                        rsp_rdata          <= m_we ? 32'd0 : m_rdata;
                        r_cnt              <= 16'd0;
                    end else if (r_cnt >= TO_CNT) begin
                        r_state            <= ST_RESP;
                        rsp_valid[r_grant] <= 1'b1;
                        rsp_err            <= 1'b1;
                        rsp_rdata          <= 32'd0;
                        timeout_o          <= 1'b1;
                        r_cnt              <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    m_we    <= 1'b0;
                    m_addr  <= 32'd0;
                    m_wdata <= 32'd0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Self-checking bench for axil_req_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_axil_req_arbiter;
    localparam int NREQ = 3;
    localparam int TO   = 8;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_we;
    logic [32*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic                m_start;
    logic                m_we;
    logic [31:0]         m_addr;
    logic [31:0]         m_wdata;
    logic                m_done;
    logic                m_error;
    logic [31:0]         m_rdata;
    logic                busy;
    logic                timeout_o;

    int checks = 0;
    int errors = 0;
    int exp_last;
    bit exp_to;

    axil_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start(m_start), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_error(m_error), .m_rdata(m_rdata),
        .busy(busy), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: walk forward from the last grant, first valid wins
    function automatic int rr_pick(input logic [NREQ-1:0] v);
        for (int d = 1; d <= NREQ; d++) begin
            int i;
            i = (exp_last + d) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we,
                           input logic [32*NREQ-1:0] ad, input logic [32*NREQ-1:0] wd,
                           input int k, input bit do_done, input bit merr,
                           input logic [31:0] mrd, input bit spur, input bit keep);
        int          w;
        int          c_end;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] oh;
        logic [31:0] e_rd;
        bit          wbit;
        bit          mis;
        bit          tmo;
        bit          e_err;
        req_valid = v;
        req_we    = we;
        req_addr  = ad;
        req_wdata = wd;
        if (spur) begin
            m_done  = 1'b1;
            m_error = 1'b1;
        end
        #1;
        w = rr_pick(v);
        if (w < 0) begin
            oh = 32'd0;
        end else begin
            oh = 32'd1 << w;
        end
        chk("ready_idle", 32'(req_ready), oh);
        if (w < 0) w = 0;
        a        = ad[32*w +: 32];
        d        = wd[32*w +: 32];
        wbit     = we[w];
        mis      = (a[1:0] != 2'b00);
        exp_last = w;
        tmo      = 1'b0;
        step();
        m_done  = 1'b0;
        m_error = 1'b0;
        if (!keep) req_valid = '0;
        #1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_busy", 32'(req_ready), 32'd0);
        if (mis) begin
            chk("no_start_misaligned", 32'(m_start), 32'd0);
        end else begin
            chk("m_start", 32'(m_start), 32'd1);
            chk("m_addr", m_addr, a);
            chk("m_we", 32'(m_we), 32'(wbit));
            chk("m_wdata", m_wdata, d);
            chk("rsp_early", 32'(rsp_valid), 32'd0);
            if (spur) begin
                m_done  = 1'b1;
                m_error = 1'b1;
                m_rdata = $urandom;
            end
            tmo   = !(do_done && (k <= TO));
            c_end = tmo ? TO : k;
            for (int c = 1; c <= c_end; c++) begin
                step();
                if ((c == c_end) && !tmo) begin
                    m_done  = 1'b1;
                    m_error = merr;
                    m_rdata = mrd;
                end else begin
                    m_done  = 1'b0;
                    m_error = 1'b0;
                    m_rdata = $urandom;
                end
                if (c == 1) chk("m_start_pulse", 32'(m_start), 32'd0);
                if (c == c_end) chk("rsp_wait", 32'(rsp_valid), 32'd0);
            end
            step();
            m_done  = 1'b0;
            m_error = 1'b0;
            m_rdata = $urandom;
            chk("m_addr_resp", m_addr, a);
        end
        e_err  = mis || tmo || merr;
        e_rd   = (mis || tmo || wbit) ? 32'd0 : mrd;
        exp_to = exp_to | tmo;
        chk("rsp_valid", 32'(rsp_valid), oh);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("timeout_o", 32'(timeout_o), 32'(exp_to));
        chk("ready_resp", 32'(req_ready), 32'd0);
        step();
        chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("m_addr_idle", m_addr, 32'd0);
        chk("rsp_rdata_hold", rsp_rdata, e_rd);
        chk("rsp_err_hold", 32'(rsp_err), 32'(e_err));
    endtask

    initial begin
        logic [NREQ-1:0]    v;
        logic [NREQ-1:0]    we;
        logic [32*NREQ-1:0] ad;
        logic [32*NREQ-1:0] wd;
        logic [31:0]        a;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_done    = 1'b0;
        m_error   = 1'b0;
        m_rdata   = 32'd0;
        exp_last  = NREQ - 1;
        exp_to    = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Single write, m_done three cycles after m_start
        ad = '0; wd = '0;
        ad[31:0] = 32'h0000_1000; wd[31:0] = 32'hDEAD_BEEF;
        run_txn(3'b001, 3'b001, ad, wd, 3, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        // Read from requester 1
        ad[63:32] = 32'h0000_0010;
        run_txn(3'b010, 3'b000, ad, wd, 2, 1'b1, 1'b0, 32'hCAFE_BABE, 1'b0, 1'b0);
        // Misaligned address
        ad[31:0] = 32'h0000_1002;
        run_txn(3'b001, 3'b000, ad, wd, 1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        // Done coinciding with the last allowed wait cycle, with spurious done elsewhere
        ad[95:64] = 32'h0000_2000;
        run_txn(3'b100, 3'b000, ad, wd, TO, 1'b1, 1'b1, 32'h5A5A_0001, 1'b1, 1'b0);
        // Timeout, then a normal transaction with timeout_o held
        run_txn(3'b100, 3'b000, ad, wd, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ad[31:0] = 32'h0000_3000;
        run_txn(3'b001, 3'b000, ad, wd, 1, 1'b1, 1'b0, 32'h7777_8888, 1'b0, 1'b0);

        // Contention from reset: req0 and req1 held continuously
        rst_n     = 1'b0;
        req_valid = 3'b011;
        exp_last  = NREQ - 1;
        exp_to    = 1'b0;
        step();
        rst_n = 1'b1;
        ad = '0;
        ad[31:0] = 32'h0000_0100; ad[63:32] = 32'h0000_0200;
        for (int n = 0; n < 4; n++) begin
            run_txn(3'b011, 3'b000, ad, wd, n + 1, 1'b1, 1'b0, $urandom, 1'b0, 1'b1);
            chk("contention_grant", 32'(exp_last), 32'(n % 2));
        end
        req_valid = '0;
        step();

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            v  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            we = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                ad[32*r +: 32] = a;
                wd[32*r +: 32] = $urandom;
            end
            run_txn(v, we, ad, wd, $urandom_range(1, 10), ($urandom_range(0, 5) != 0),
                    ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Reset while waiting on the master drops the transaction
        ad = '0;
        ad[31:0] = 32'h0000_4000;
        req_addr  = ad;
        req_we    = '0;
        req_valid = 3'b001;
        step();
        req_valid = '0;
        step();
        step();
        chk("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp", 32'(rsp_valid), 32'd0);
        chk("midrst_timeout", 32'(timeout_o), 32'd0);
        chk("midrst_m_addr", m_addr, 32'd0);
        step();
        step();
        chk("midrst_rsp_hold", 32'(rsp_valid), 32'd0);
        rst_n    = 1'b1;
        exp_last = NREQ - 1;
        exp_to   = 1'b0;
        step();
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        ad[63:32] = 32'h0000_5000;
        run_txn(3'b011, 3'b000, ad, wd, 2, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
        chk("post_rst_grant", 32'(exp_last), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_req_arbiter.md
AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 2, number of requesters (2..8) / TIMEOUT, 255, max wait cycles for m_done (1..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  NREQ  per-requester transaction request.
REQ-005 req_ready  output  NREQ  per-requester acceptance; one-hot or zero.
REQ-006 req_we  input  NREQ  per-requester 1=write, 0=read.
REQ-007 req_addr  input  32*NREQ  packed byte addresses; requester i at bits [32i+31:32i].
REQ-008 req_wdata  input  32*NREQ  packed write data, same packing.
REQ-009 rsp_valid  output  NREQ  one-cycle completion pulse to the owning requester.
REQ-010 rsp_rdata  output  32  read data; valid with rsp_valid.
REQ-011 rsp_err  output  1  completion error flag; valid with rsp_valid.
REQ-012 m_start  output  1  one-cycle start pulse to the AXI-Lite master.
REQ-013 m_we / m_addr / m_wdata  output  1/32/32  command to master.
REQ-014 m_done / m_error  input  1/1  master completion pulse and error flag.
REQ-015 m_rdata  input  32  master read data; valid with m_done.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_o  output  1  sticky; set on any timeout; cleared only by reset.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-019 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NREQ; the first asserted req_valid wins.
REQ-020 In IDLE, req_ready SHALL be asserted combinationally for the winner only; when no req_valid is asserted, req_ready SHALL be 0.
REQ-021 On acceptance, the block SHALL capture we/addr/wdata and the grant index, and update last_grant.
REQ-022 Accepted addr with addr[1:0]!=0 SHALL skip the master: next state RESP with rsp_err=1 and rsp_rdata=0; m_start SHALL stay 0.
REQ-023 Otherwise the next state SHALL be ISSUE; m_start=1 for exactly that one cycle, then WAIT.
REQ-024 m_we/m_addr/m_wdata SHALL hold the captured values from ISSUE through RESP; they SHALL be 0 in IDLE.
REQ-025 WAIT SHALL count cycles from 1.
  - m_done=1: go to RESP with rsp_err=m_error; rsp_rdata=m_rdata for reads, 0 for writes.
  - Count reaches TIMEOUT without m_done: go to RESP with rsp_err=1, rsp_rdata=0; set timeout_o.
REQ-026 When m_done and timeout expiry occur in the same cycle, m_done SHALL win; timeout_o SHALL NOT be set.
REQ-027 m_done or m_error in IDLE, ISSUE or RESP SHALL be ignored.
REQ-028 RESP SHALL assert rsp_valid[grant] for one cycle, then return to IDLE; no new request is accepted in RESP.
REQ-029 Latency from acceptance to rsp_valid SHALL be: aligned, k = cycles from m_start to m_done -> k+2; misaligned -> 1.
REQ-030 rsp_rdata and rsp_err SHALL hold their last values outside RESP.

Reset
REQ-031 On rst_n=0, asynchronously:
  - state = IDLE;
  - all outputs = 0, including timeout_o;
  - counter = 0;
  - last_grant = NREQ-1, so requester 0 has first priority.
REQ-032 Reset mid-transaction SHALL drop the transaction without a rsp_valid pulse.

Verification
REQ-033 Single write: req0 we=1, addr 0x1000, data 0xDEADBEEF; m_done 3 cycles after m_start -> m_start one pulse with m_addr=0x1000, m_wdata=0xDEADBEEF; rsp_valid[0] at acceptance+5; rsp_err=0.
REQ-034 Read: req1 we=0, addr 0x0010; m_rdata=0xCAFEBABE with m_done -> rsp_valid[1] with rsp_rdata=0xCAFEBABE.
REQ-035 Contention: req0 and req1 held continuously from reset -> grants 0,1,0,1; no requester granted twice in a row.
REQ-036 Misaligned: addr 0x1002 -> no m_start; rsp_err=1 one cycle after acceptance.
REQ-037 Timeout: TIMEOUT=8, m_done never asserted -> rsp_err=1 at WAIT count 8; timeout_o=1 and held; next transaction proceeds normally.
REQ-038 Reset in WAIT: rst_n low for 2 cycles -> busy=0 and no rsp_valid; after release, req1 and req0 both asserted -> req0 granted first.
